// File: rtl/axis_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_arb_pkg
// Purpose  : Shared types and default widths for the AXI-Stream packet
//            round-robin arbiter and its output skid buffer.
// Contents : arb_state_e - arbiter state enumeration (IDLE, GNT0, GNT1)
//            DATA_W_DEF  - default tdata width
//            CNT_W_DEF   - default per-source packet counter width
// Revision : 1.0 - initial release
// ============================================================================
package axis_arb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

endpackage : axis_arb_pkg
`default_nettype wire

// File: rtl/axis_skid.sv
`default_nettype none
// ============================================================================
// Module   : axis_skid
// Purpose  : Two-entry skid buffer. It sustains one beat per cycle while the
//            sink is ready and absorbs up to two beats when the sink stalls,
//            so the upstream ready only has to drop once both entries are full.
// Ports    : clk_i/rst_i      - clock, asynchronous active-high reset
//            s_data_i/s_valid_i/s_ready_o - upstream payload handshake
//            m_data_o/m_valid_o/m_ready_i - downstream payload handshake
// Revision : 1.0 - initial release
// ============================================================================
module axis_skid
  import axis_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W_DEF + 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);

  // Payload storage is deliberately not reset: it is only observed while the
  // occupancy count says the entry holds a live beat.
  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             push;
  logic             pop;

  assign s_ready_o = (cnt_q != 2'd2);
  assign m_valid_o = (cnt_q != 2'd0);
  assign m_data_o  = mem_q[rd_ptr_q];
  assign push      = s_valid_i & s_ready_o;
  assign pop       = m_valid_o & m_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= s_data_i;
  end

endmodule : axis_skid
`default_nettype wire

// File: rtl/axis_pkt_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_rr_arb
// Purpose  : Packet-granular round-robin arbiter merging two AXI-Stream
//            sources onto one master through a 2-entry skid buffer. A grant
//            is held until the granted source's tlast beat transfers, then
//            the arbiter spends one IDLE cycle before the next grant.
// Ports    : axis_aclk/axis_areset       - clock, async active-high reset
//            s0_axis_*                   - source 0 slave stream
//            s1_axis_*                   - source 1 slave stream
//            m_axis_* / m_axis_tid       - merged master stream, source index
//            pkt_cnt0 / pkt_cnt1         - wrapping completed-packet counts
// Revision : 1.0 - initial release
// ============================================================================
module axis_pkt_rr_arb
  import axis_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              axis_aclk,
  input  logic              axis_areset,

  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic              s0_axis_tvalid,
  output logic              s0_axis_tready,
  input  logic              s0_axis_tlast,

  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tvalid,
  output logic              s1_axis_tready,
  input  logic              s1_axis_tlast,

  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tid,

  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  localparam int unsigned PAY_W = DATA_W + 2;

  arb_state_e        state_q;
  logic              last_grant_q;
  logic [CNT_W-1:0]  cnt0_q;
  logic [CNT_W-1:0]  cnt1_q;

  logic              skid_rdy;
  logic              xfer0;
  logic              xfer1;
  logic              sel_gnt1;
  logic [PAY_W-1:0]  skid_in;
  logic [PAY_W-1:0]  skid_out;
  logic              skid_vld;

  // Ready is only offered to the granted source; IDLE always stalls both.
  assign s0_axis_tready = (state_q == GNT0) & skid_rdy;
  assign s1_axis_tready = (state_q == GNT1) & skid_rdy;
  assign xfer0          = s0_axis_tvalid & s0_axis_tready;
  assign xfer1          = s1_axis_tvalid & s1_axis_tready;

  // Payload packing: {tid, tlast, tdata}.
  assign sel_gnt1 = (state_q == GNT1);
  assign skid_in  = sel_gnt1 ? {1'b1, s1_axis_tlast, s1_axis_tdata}
                             : {1'b0, s0_axis_tlast, s0_axis_tdata};

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_q      <= IDLE;
      // Pointing at source 1 makes source 0 win the first tie after reset.
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s0_axis_tvalid && s1_axis_tvalid)
            state_q <= last_grant_q ? GNT0 : GNT1;
          else if (s0_axis_tvalid)
            state_q <= GNT0;
          else if (s1_axis_tvalid)
            state_q <= GNT1;
        end
        GNT0: begin
          if (xfer0 && s0_axis_tlast) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            cnt0_q       <= cnt0_q + 1'b1;
          end
        end
        GNT1: begin
          if (xfer1 && s1_axis_tlast) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt1_q       <= cnt1_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axis_skid #(
    .WIDTH (PAY_W)
  ) u_skid (
    .clk_i     (axis_aclk),
    .rst_i     (axis_areset),
    .s_data_i  (skid_in),
    .s_valid_i (xfer0 | xfer1),
    .s_ready_o (skid_rdy),
    .m_data_o  (skid_out),
    .m_valid_o (skid_vld),
    .m_ready_i (m_axis_tready)
  );

  // Sideband bits are qualified by valid so tid/tlast read 0 while the buffer
  // is empty (including during reset), since the storage itself is not reset.
  assign m_axis_tvalid = skid_vld;
  assign m_axis_tdata  = skid_out[DATA_W-1:0];
  assign m_axis_tlast  = skid_vld & skid_out[DATA_W];
  assign m_axis_tid    = skid_vld & skid_out[DATA_W+1];

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

endmodule : axis_pkt_rr_arb
`default_nettype wire

// File: doc/axis_pkt_rr_arb.md
AXIS_PKT_RR_ARB -- requirements
Module: axis_pkt_rr_arb

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32, the tdata width of all streams.
REQ-002 The block SHALL expose parameter CNT_W, default 16, the width of each per-source packet counter.
REQ-003 Port axis_aclk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 Port axis_areset  input  1  asynchronous, active-high reset.
REQ-005 Ports s0_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATA_W/1/1/1  source 0 AXI-Stream slave.
REQ-006 Ports s1_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATA_W/1/1/1  source 1 AXI-Stream slave.
REQ-007 Ports m_axis_tdata/tvalid/tready/tlast  out/out/in/out  DATA_W/1/1/1  merged AXI-Stream master.
REQ-008 Port m_axis_tid  output  1  source index of the beat on m_axis_tdata.
REQ-009 Ports pkt_cnt0, pkt_cnt1  output  CNT_W  completed-packet counts per source.

Function
REQ-010 The block SHALL have three states: IDLE, GNT0, GNT1.
REQ-011 In IDLE, s0/s1 tready SHALL be 0, and the state SHALL go to GNTx next cycle when only sx_axis_tvalid=1.
REQ-012 In IDLE with both tvalid=1, the block SHALL grant the source not equal to last_grant.
REQ-013 In GNTx, sx_axis_tready SHALL equal the output stage's input-ready, and the other source's tready SHALL be 0.
REQ-014 A beat SHALL transfer on sx_axis_tvalid & sx_axis_tready, and the block SHALL NOT move data on any other condition.
REQ-015 On a transfer with tlast=1 in GNTx, the state SHALL return to IDLE and last_grant SHALL become x.
REQ-016 Grant SHALL be held for the whole packet: no switch before the tlast beat, regardless of the other source's tvalid.
REQ-017 Each packet SHALL incur exactly one IDLE bubble cycle between its tlast transfer and the next grant.
REQ-018 A beat accepted in cycle N SHALL first appear with m_axis_tvalid=1 in cycle N+1, with tdata, tlast and tid = granted index.
REQ-019 The output stage SHALL be a 2-entry skid buffer that sustains 1 beat/cycle while m_axis_tready=1 and drops no beat when m_axis_tready falls.
REQ-020 The output stage SHALL deassert input-ready only when both entries are full, and SHALL present beats in order.
REQ-021 pkt_cntx SHALL increment by 1 on each source-x tlast transfer and SHALL wrap from 2^CNT_W-1 to 0.
REQ-022 A tvalid drop mid-packet on the granted source SHALL hold the state; the grant SHALL persist indefinitely until tlast.
REQ-023 Single-beat packets (tvalid&tlast on the first beat) SHALL be legal and SHALL increment the counter.

Reset
REQ-024 axis_areset=1 SHALL immediately force state=IDLE, last_grant=1, skid buffer empty, m_axis_tvalid=0, both tready=0, m_axis_tid=0 and both counters=0.
REQ-025 Reset asserted mid-packet SHALL discard the buffered beats and the partial packet; after release, arbitration SHALL restart from IDLE with source 0 winning the first tie.
REQ-026 m_axis_tdata SHALL be don't-care while m_axis_tvalid=0, and the datapath registers need not be reset.

Structure
REQ-027 Package axis_arb_pkg SHALL hold the state enumeration (IDLE, GNT0, GNT1) and the default DATA_W and CNT_W constants.
REQ-028 The output stage SHALL be the sub-module axis_skid, parameterised on payload width DATA_W+2 (tdata, tlast, tid), with the same clock and active-high reset.
REQ-029 The FSM, grant mux, last_grant pointer and counters SHALL reside in axis_pkt_rr_arb.

Verification
REQ-030 Source 0 sends a 3-beat packet 0xA0..0xA2 with m_axis_tready=1 -> m_axis_tvalid high for 3 consecutive cycles starting 2 cycles after tvalid, tid=0, tlast on 0xA2, pkt_cnt0=1.
REQ-031 Both sources hold tvalid from reset release, each sending 2-beat packets -> grant order 0,1,0,1 with one bubble cycle between packets.
REQ-032 Source 1 sends a 4-beat packet and m_axis_tready toggles 1,0,0,1,... -> all 4 beats are delivered in order with no duplicate or loss, and s1_axis_tready drops within the same cycle the skid buffer fills.
REQ-033 Source 0 is granted and source 1 asserts tvalid during beat 2 of 5 -> source 1 sees tready=0 until source 0's tlast has transferred plus one IDLE cycle.
REQ-034 pkt_cnt0 is preloaded by sending 65535 single-beat packets, then one more is sent -> pkt_cnt0 wraps to 0.
REQ-035 axis_areset pulses during beat 2 of a source 1 packet -> outputs are at reset values in the same cycle, and the next simultaneous request grants source 0.
